prog_clock_divider: RTL and testbench

- Next-generation divider. Replaces fixed /2, /4, /8, /16 outputs with one runtime-programmable divided clock (ratio 2..2^CNT_W-1).
- Keeps a parametrised bank of free-running power-of-two taps.
- Ratio changes and enable/disable are glitch-free: they take effect only on output-period boundaries.
- Sits at the clock-generation tier, feeding peripheral clock enables and slow sampling domains.

---
 rtl/prog_clock_divider.sv | 125 ++++++++++++
 tb/tb_prog_clock_divider.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable divided clock plus a bank of free-running power-of-two taps.
// Optional build macro CLKDIV_ODD_DUTY50_EN: exact 50% duty on odd ratios using one negedge flop.
module prog_clock_divider #(
    parameter int CNT_W       = 8,
    parameter int TAP_N       = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic             clk_out,
    output logic             clk_out_tick,
    output logic [TAP_N-1:0] taps
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] hi_d;
    logic [TAP_N-1:0] taps_q, taps_d;
    logic             clk_pos_q, clk_pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             wrap, load_ok, run_d;

    assign wrap    = cnt_q == active_q - CNT_W'(1);
    assign err_d   = div_load && (div_val < CNT_W'(2) || state_q == S_PEND);
    assign load_ok = div_load && !err_d;

    // Next-state logic: ratio changes and stops only land on period boundaries.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        active_d = active_q;
        pend_d   = pend_q;
        taps_d   = taps_q + TAP_N'(1);
        case (state_q)
            S_IDLE: begin
                state_d = en ? S_RUN : S_IDLE;
                if (load_ok) active_d = div_val;
            end
            S_RUN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (wrap && !en) begin
                    state_d = S_IDLE;
                    if (load_ok) active_d = div_val;
                end else if (load_ok) begin
                    state_d = S_PEND;
                    pend_d  = div_val;
                end
            end
            default: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (wrap) begin
                    active_d = pend_q;
                    state_d  = en ? S_RUN : S_IDLE;
                end
            end
        endcase
`ifdef CLKDIV_ODD_DUTY50_EN
        hi_d      = active_d >> 1;
`else
        hi_d      = (active_d >> 1) + CNT_W'(active_d[0]);
`endif
        run_d     = state_d != S_IDLE;
        clk_pos_d = run_d && (cnt_d < hi_d);
        tick_d    = run_d && (cnt_d == '0);
    end

    // Divider state, counters and registered outputs; reset truncates any period in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            active_q  <= DEF_DIV;
            pend_q    <= DEF_DIV;
            taps_q    <= '0;
            clk_pos_q <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            taps_q    <= taps_d;
            clk_pos_q <= clk_pos_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    logic neg_q, neg_d;

    // Half-cycle copy of the posedge output, only used to stretch odd-ratio high phases.
    always_comb begin
        neg_d = active_q[0] & clk_pos_q;
    end

    // Negedge stage: ORed with the posedge output to give N/2 clocks high on odd N.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= neg_d;
    end

    assign clk_out = clk_pos_q | neg_q;
`else
    assign clk_out = clk_pos_q;
`endif

    assign clk_out_tick = tick_q;
    assign div_busy     = state_q == S_PEND;
    assign div_err      = err_q;
    assign taps         = taps_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: randomized self-checking bench against a period-queue reference model.
module tb_prog_clock_divider;
    localparam int CNT_W       = 8;
    localparam int TAP_N       = 4;
    localparam int DEFAULT_DIV = 4;
    localparam int VW          = TAP_N + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_busy, div_err, clk_out, clk_out_tick;
    logic [TAP_N-1:0] taps;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each started period is expanded into a queue of expected clk_out levels.
    int m_ratio = DEFAULT_DIV;
    int m_pend  = -1;
    int m_taps  = 0;
    bit m_run = 0, m_out = 0, m_tick = 0, m_err = 0;
    bit m_q[$];

    prog_clock_divider #(.CNT_W(CNT_W), .TAP_N(TAP_N), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
        .div_busy(div_busy), .div_err(div_err), .clk_out(clk_out),
        .clk_out_tick(clk_out_tick), .taps(taps)
    );

    always #20 clk = ~clk;

    function automatic void m_reset();
        m_ratio = DEFAULT_DIV;
        m_pend  = -1;
        m_taps  = 0;
        m_run   = 0;
        m_out   = 0;
        m_tick  = 0;
        m_err   = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge(bit e, bit ld, int v);
        bit acc;
        m_err  = ld && (v < 2 || m_pend >= 0);
        acc    = ld && !m_err;
        m_taps = (m_taps + 1) % (1 << TAP_N);
        m_tick = 0;
        if (m_run && m_q.size() > 0) begin
            m_out = m_q.pop_front();
            if (acc) m_pend = v;
        end else begin
            if (m_pend >= 0) begin
                m_ratio = m_pend;
                m_pend  = -1;
            end
            if (acc && m_run && e) m_pend = v;
            else if (acc) m_ratio = v;
            m_run = e;
            m_out = 0;
            if (e) begin
                for (int i = 0; i < m_ratio; i++) m_q.push_back(i < (m_ratio + 1) / 2);
                m_out  = m_q.pop_front();
                m_tick = 1;
            end
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [31:0] t;
        t = m_taps;
        return {m_out, m_tick, m_pend >= 0, m_err, t[TAP_N-1:0]};
    endfunction

    task automatic step(bit e, bit ld, int v);
        logic [31:0] vv;
        vv = v;
        en = e;
        div_load = ld;
        div_val = vv[CNT_W-1:0];
        @(posedge clk);
        model_edge(e, ld, v);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got %b expected %b", {clk_out, clk_out_tick, div_busy, div_err, taps}, {VW{1'b0}});
        end
        rst = 1'b1;
        m_reset();
    endtask

    task automatic test_default_run();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL default_run cyc %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
    endtask

    task automatic test_load(int v);
        step(1, 0, 0);
        step(1, 1, v);
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL load_%0d cyc %0d: got %b expected %b", v, i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
            step(1, 0, 0);
        end
    endtask

    task automatic test_errors();
        int n_err;
        int vals[5] = '{0, 1, 9, 7, 0};
        bit lds[5]  = '{1, 1, 1, 1, 0};
        n_err = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, lds[i], vals[i]);
            if (div_err) n_err++;
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL errors step %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
        vectors++;
        if (n_err !== 3) begin
            miscompares++;
            $display("FAIL err_pulse_count: got %0d expected 3", n_err);
        end
        for (int i = 0; i < 24; i++) begin
            step(1, 0, 0);
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL errors_after cyc %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
    endtask

    task automatic test_en_drop();
        int highs;
        repeat (16) step(0, 0, 0);
        step(0, 1, 8);
        step(1, 0, 0);
        highs = clk_out ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0);
            if (clk_out) highs++;
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_drop cyc %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
        vectors++;
        if (highs !== 4) begin
            miscompares++;
            $display("FAIL en_drop_high_cycles: got %0d expected 4", highs);
        end
        step(1, 0, 0);
        vectors++;
        if ({clk_out, clk_out_tick} !== 2'b11 || {clk_out, clk_out_tick} !== {m_out, m_tick}) begin
            miscompares++;
            $display("FAIL en_reassert: got %b expected 11", {clk_out, clk_out_tick});
        end
    endtask

    task automatic test_random();
        bit e, ld;
        int v;
        for (int i = 0; i < 3000; i++) begin
            e  = $urandom_range(0, 99) < 92;
            ld = $urandom_range(0, 99) < 6;
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            step(e, ld, v);
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (300) step(0, 0, 0);
        step(0, 1, 10);
        step(1, 0, 0);
        step(1, 0, 0);
        vectors++;
        if (clk_out !== 1'b1 || m_out !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_high: got %b expected 1", clk_out);
        end
        #4 rst = 1'b0;
        #5;
        vectors++;
        if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", {clk_out, clk_out_tick, div_busy, div_err, taps}, {VW{1'b0}});
        end
        #5 rst = 1'b1;
        m_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0);
            vectors++;
            if ({clk_out, clk_out_tick, div_busy, div_err, taps} !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: got %b expected %b", i, {clk_out, clk_out_tick, div_busy, div_err, taps}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_load(6);
        test_load(5);
        test_errors();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
